// File: rtl/gnpu_pkg.sv
// gnpu_pkg: shared widths and drain FSM states for the sarray store path
package gnpu_pkg;
  localparam int SARRAY_STORE_WIDTH = 512;
  localparam int TMMA_CNT_WIDTH = 4;
  typedef enum logic [2:0] {IDLE, REQ, COLLECT, FLUSH, DONE} drain_state_e;
endpackage

// File: rtl/sarray_store_drain_if.sv
// sarray_store_drain_if: store beat port from the drain to memory
interface sarray_store_drain_if #(parameter int ADDR_W = 32, parameter int MEM_W = 128);
  logic st_valid_o;
  logic st_ready_i;
  logic [ADDR_W-1:0] st_addr_o;
  logic [MEM_W-1:0] st_data_o;
  logic st_last_o;
  modport master(output st_valid_o, st_addr_o, st_data_o, st_last_o, input st_ready_i);
  modport slave(input st_valid_o, st_addr_o, st_data_o, st_last_o, output st_ready_i);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO; push and pop may coincide even when full
module sync_fifo #(parameter int WIDTH = 8, parameter int DEPTH = 16) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/sarray_store_drain.sv
// sarray_store_drain: requests a C tile from sarray, buffers rows, writes them out as store beats
module sarray_store_drain
  import gnpu_pkg::*;
#(
  parameter int STORE_W = SARRAY_STORE_WIDTH,
  parameter int CNT_W = TMMA_CNT_WIDTH,
  parameter int DEPTH = 16,
  parameter int MEM_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drain_start_i,
  input  logic [CNT_W:0] drain_rows_i,
  input  logic [ADDR_W-1:0] drain_addr_i,
  output logic drain_busy_o,
  output logic drain_done_o,
  output logic drain_err_o,
  output logic post_storec_valid_o,
  input  logic in_valid_i,
  input  logic [CNT_W-1:0] in_cnt_i,
  input  logic [STORE_W-1:0] in_data_i,
  sarray_store_drain_if.master st
);
  localparam int NBEAT = STORE_W / MEM_W;
  localparam int BW = NBEAT > 1 ? $clog2(NBEAT) : 1;
  localparam int IW = CNT_W + 1 + BW;
  localparam int CW = $clog2(DEPTH) + 1;
  drain_state_e state, state_n;
  logic [CNT_W:0] rows_q, exp_row;
  logic [ADDR_W-1:0] base_q;
  logic err, sfull;
  logic [STORE_W-1:0] sreg, f_dout;
  logic [BW-1:0] beat;
  logic [IW-1:0] beat_idx;
  logic [CW-1:0] f_count, free;
  logic f_push, f_pop, f_full, f_empty;
  logic accept, row_end, load, row_in, bypass, overflow, err_evt, start, room;
  sync_fifo #(.WIDTH(STORE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(f_push), .pop(f_pop), .din(in_data_i),
    .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );
  assign start = state == IDLE && drain_start_i;
  assign accept = sfull && st.st_ready_i;
  assign row_end = beat == BW'(NBEAT - 1);
  assign load = !sfull || (accept && row_end);
  assign row_in = in_valid_i && state == COLLECT;
  assign f_pop = load && !f_empty;
  // an empty FIFO lets a row go straight into the serializer for single-cycle latency
  assign bypass = load && f_empty && row_in;
  assign f_push = row_in && !bypass && (!f_full || f_pop);
  assign overflow = row_in && f_full && !f_pop;
  assign err_evt = (in_valid_i && state != COLLECT) || overflow || (row_in && in_cnt_i != exp_row[CNT_W-1:0]);
  assign free = CW'(DEPTH) - f_count;
  assign room = free >= CW'(rows_q);
  assign post_storec_valid_o = state == REQ && room;
  assign drain_busy_o = state != IDLE;
  assign drain_done_o = state == DONE;
  assign drain_err_o = err;
  assign st.st_valid_o = sfull;
  assign st.st_data_o = sreg[beat*MEM_W +: MEM_W];
  assign st.st_addr_o = base_q + ADDR_W'(beat_idx) * ADDR_W'(MEM_W / 8);
  assign st.st_last_o = sfull && beat_idx == IW'(rows_q) * IW'(NBEAT) - IW'(1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = drain_start_i ? (drain_rows_i == '0 ? DONE : REQ) : IDLE;
      REQ:     state_n = room ? COLLECT : REQ;
      COLLECT: state_n = row_in && exp_row + (CNT_W+1)'(1) == rows_q ? FLUSH : COLLECT;
      FLUSH:   state_n = accept && st.st_last_o ? DONE : FLUSH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rows_q <= '0;
      base_q <= '0;
      exp_row <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        rows_q <= drain_rows_i;
        base_q <= drain_addr_i;
        exp_row <= '0;
        err <= 1'b0;
      end else begin
        err <= err | err_evt;
        if (row_in) exp_row <= exp_row + (CNT_W+1)'(1);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      sfull <= 1'b0;
      beat <= '0;
      beat_idx <= '0;
    end else begin
      if (f_pop || bypass) begin
        sreg <= f_pop ? f_dout : in_data_i;
        sfull <= 1'b1;
        beat <= '0;
      end else if (accept) begin
        sfull <= !row_end;
        beat <= row_end ? '0 : beat + BW'(1);
      end
      if (start) beat_idx <= '0;
      else if (accept) beat_idx <= beat_idx + IW'(1);
    end
endmodule

// File: tb/tb_sarray_store_drain.sv
// tb_sarray_store_drain: directed tiles with a queued scoreboard checked by a beat monitor
module tb_sarray_store_drain;
  typedef struct {
    logic [31:0] addr;
    logic [127:0] data;
    logic last;
  } beat_t;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [4:0] rows = '0;
  logic [31:0] addr = '0;
  logic [3:0] in_cnt = '0;
  logic [511:0] in_data = '0;
  logic busy, done, err, post;
  int checks = 0, errors = 0, cyc = 0, post_cnt = 0, last_cyc = -10, ready_mode = 0;
  beat_t exp_q[$];
  sarray_store_drain_if #(.ADDR_W(32), .MEM_W(128)) stb();
  sarray_store_drain dut (
    .clk(clk), .rst_n(rst_n), .drain_start_i(start), .drain_rows_i(rows), .drain_addr_i(addr),
    .drain_busy_o(busy), .drain_done_o(done), .drain_err_o(err), .post_storec_valid_o(post),
    .in_valid_i(in_valid), .in_cnt_i(in_cnt), .in_data_i(in_data), .st(stb.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    stb.st_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 stb.st_ready_i = ready_mode != 0 ? ~stb.st_ready_i : 1'b1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
  always @(negedge clk)
    if (rst_n) begin
      if (post) post_cnt++;
      if (stb.st_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected addr=%h data=%h", stb.st_addr_o, stb.st_data_o);
        end else begin
          if (stb.st_addr_o !== exp_q[0].addr || stb.st_data_o !== exp_q[0].data || stb.st_last_o !== exp_q[0].last) begin
            errors++;
            $display("FAIL beat got addr=%h data=%h last=%b exp addr=%h data=%h last=%b",
                     stb.st_addr_o, stb.st_data_o, stb.st_last_o, exp_q[0].addr, exp_q[0].data, exp_q[0].last);
          end
          if (stb.st_ready_i) begin
            if (exp_q[0].last) last_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  function automatic logic [127:0] beat_val(int tag, int i, int b);
    return {32'(tag), 32'(i), 32'(b), 32'hA5C3_0000 + 32'(tag * 16 + i * 4 + b)};
  endfunction
  function automatic logic [511:0] row_data(int tag, int i);
    logic [511:0] r;
    for (int b = 0; b < 4; b++) r[b*128 +: 128] = beat_val(tag, i, b);
    return r;
  endfunction
  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(int n, logic [31:0] a);
    start = 1'b1;
    rows = 5'(n);
    addr = a;
    step();
    start = 1'b0;
  endtask
  task automatic wait_post();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (post) break;
    end
    chk("post_seen", k < 20, 1);
    step();
  endtask
  task automatic wait_done(output int dc);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    dc = cyc;
    chk("done_seen", k < 300, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask
  task automatic push_exp(int tag, int n, logic [31:0] base);
    beat_t e;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) begin
        e.addr = base + 32'((i * 4 + b) * 16);
        e.data = beat_val(tag, i, b);
        e.last = i == n - 1 && b == 3;
        exp_q.push_back(e);
      end
  endtask
  task automatic drive_rows(int tag, int n, int ord[4]);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_cnt = 4'(ord[i]);
      in_data = row_data(tag, i);
      step();
    end
    in_valid = 1'b0;
  endtask
  task automatic run_tile(int tag, int n, logic [31:0] base, int ord[4], logic exp_err);
    int p0, dc;
    push_exp(tag, n, base);
    p0 = post_cnt;
    pulse_start(n, base);
    chk("err_clear_on_start", err, 0);
    chk("busy", busy, 1);
    wait_post();
    drive_rows(tag, n, ord);
    wait_done(dc);
    chk("done_after_last", dc, last_cyc + 1);
    chk("post_count", post_cnt - p0, 1);
    chk("err", err, exp_err);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle", busy, 0);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_post"}, post, 0);
    chk({tag, "_valid"}, stb.st_valid_o, 0);
    chk({tag, "_addr"}, stb.st_addr_o, 0);
    chk({tag, "_data"}, stb.st_data_o, 0);
    chk({tag, "_last"}, stb.st_last_o, 0);
  endtask
  initial begin
    int p0, s, dc;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    run_tile(1, 4, 32'h0000_1000, '{0, 1, 2, 3}, 1'b0);
    p0 = post_cnt;
    s = cyc;
    pulse_start(0, 32'h0000_8000);
    wait_done(dc);
    chk("zero_rows_latency", dc - s <= 2, 1);
    chk("zero_rows_post", post_cnt - p0, 0);
    step();
    ready_mode = 1;
    run_tile(2, 4, 32'h0000_4000, '{0, 1, 2, 3}, 1'b0);
    ready_mode = 0;
    run_tile(3, 4, 32'h0000_6000, '{0, 2, 1, 3}, 1'b1);
    step();
    in_valid = 1'b1;
    in_cnt = 4'd0;
    in_data = row_data(9, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stray_row_err", err, 1);
    step();
    run_tile(5, 2, 32'hFFFF_FFE0, '{0, 1, 0, 0}, 1'b0);
    push_exp(7, 4, 32'h0000_2000);
    pulse_start(4, 32'h0000_2000);
    wait_post();
    drive_rows(7, 2, '{0, 1, 2, 3});
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_tile(8, 4, 32'h0000_3000, '{0, 1, 2, 3}, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
